// File: rtl/alu_pipe_mc.sv
// alu_pipe_mc: handshaked ALU. Single-cycle ops are registered on accept; MUL (and DIVU/REMU
// when ALU_DIV_EN is defined) iterate one bit per cycle through BUSY before DONE.
module alu_pipe_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] source1,
  input  logic [WIDTH-1:0] source2,
  input  logic [3:0]       ALU_CTRL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD = 4'd2, OP_XOR = 4'd3,
    OP_SLL  = 4'd4,  OP_SRL  = 4'd5,  OP_SUB = 4'd6, OP_SLT = 4'd7,
    OP_SLTU = 4'd8,  OP_SRA  = 4'd9,  OP_MUL = 4'd10,
    OP_DIVU = 4'd12, OP_REMU = 4'd13
  } op_e;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_ovf, r_dz;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;

  logic             w_iter, w_last;
  logic [WIDTH-1:0] w_sum, w_diff, w_sc_result;
  logic             w_add_ovf, w_sub_ovf, w_sc_ovf;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_acc_nxt, w_it_result;
  logic             w_it_dz;

`ifdef ALU_DIV_EN
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvsr;
  logic [WIDTH:0]   w_rem_sh, w_rem_sub;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign div_zero  = r_dz;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_iter = (ALU_CTRL == OP_MUL);
`ifdef ALU_DIV_EN
    if (ALU_CTRL == OP_DIVU || ALU_CTRL == OP_REMU) w_iter = 1'b1;
`endif
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_sum       = source1 + source2;
    w_diff      = source1 - source2;
    w_add_ovf   = (source1[WIDTH-1] == source2[WIDTH-1]) && (w_sum[WIDTH-1]  != source1[WIDTH-1]);
    w_sub_ovf   = (source1[WIDTH-1] != source2[WIDTH-1]) && (w_diff[WIDTH-1] != source1[WIDTH-1]);
    w_sh        = source2[SHW-1:0];
    w_sc_result = '0;
    w_sc_ovf    = 1'b0;
    case (ALU_CTRL)
      OP_AND:  w_sc_result = source1 & source2;
      OP_OR:   w_sc_result = source1 | source2;
      OP_ADD:  begin w_sc_result = w_sum;  w_sc_ovf = w_add_ovf; end
      OP_XOR:  w_sc_result = source1 ^ source2;
      OP_SLL:  w_sc_result = source1 << w_sh;
      OP_SRL:  w_sc_result = source1 >> w_sh;
      OP_SUB:  begin w_sc_result = w_diff; w_sc_ovf = w_sub_ovf; end
      // Signed less-than from the subtractor: sign corrected by overflow.
      OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ovf};
      OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, source1 < source2};
      OP_SRA:  w_sc_result = $signed(source1) >>> w_sh;
      default: ;
    endcase
  end

  always_comb begin
    w_acc_nxt   = r_mplier[0] ? r_acc + r_mcand : r_acc;
    w_it_result = w_acc_nxt;
    w_it_dz     = 1'b0;
`ifdef ALU_DIV_EN
    // Restoring step: divisor 0 always "fits", giving all-ones quotient and remainder == A.
    w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    w_rem_ge  = (w_rem_sh >= {1'b0, r_dvsr});
    w_rem_sub = w_rem_sh - {1'b0, r_dvsr};
    w_rem_nxt = w_rem_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_rem_ge};
    if (r_op == OP_DIVU) begin
      w_it_result = w_quo_nxt;
      w_it_dz     = (r_dvsr == '0);
    end else if (r_op == OP_REMU) begin
      w_it_result = w_rem_nxt;
      w_it_dz     = (r_dvsr == '0);
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = w_iter ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`ifdef ALU_DIV_EN
      r_op     <= 4'd0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_cnt    <= '0;
          r_acc    <= '0;
          r_mcand  <= source1;
          r_mplier <= source2;
`ifdef ALU_DIV_EN
          r_op     <= ALU_CTRL;
          r_rem    <= '0;
          r_quo    <= source1;
          r_dvsr   <= source2;
`endif
          if (!w_iter) begin
            r_result <= w_sc_result;
            r_zero   <= (w_sc_result == '0);
            r_ovf    <= w_sc_ovf;
            r_dz     <= 1'b0;
          end
        end
        S_BUSY: begin
          r_cnt    <= r_cnt + CNT_W'(1);
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
`ifdef ALU_DIV_EN
          r_rem    <= w_rem_nxt;
          r_quo    <= w_quo_nxt;
`endif
          if (w_last) begin
            r_result <= w_it_result;
            r_zero   <= (w_it_result == '0);
            r_ovf    <= 1'b0;
            r_dz     <= w_it_dz;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe_mc.sv
// Self-checking bench for alu_pipe_mc (WIDTH=16): directed scenarios plus randomized ops
// against an arithmetic reference model.
module tb_alu_pipe_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] source1 = '0;
  logic [W-1:0] source2 = '0;
  logic [3:0]   ALU_CTRL = 4'd0;
  logic         in_ready, out_valid, zero, overflow, div_zero;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  alu_pipe_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .source1(source1), .source2(source2), .ALU_CTRL(ALU_CTRL),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic on the op definitions.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic ov, output logic dz,
                                output int lat);
    int sa, sb, s;
    int unsigned ua, ub;
    ua = a; ub = b;
    sa = a[15] ? int'(ua) - 65536 : int'(ua);
    sb = b[15] ? int'(ub) - 65536 : int'(ub);
    r = 16'h0000; ov = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = 16'(ua + ub); ov = (s > 32767) || (s < -32768); end
      4'd3:  r = a ^ b;
      4'd4:  r = 16'(ua << b[3:0]);
      4'd5:  r = 16'(ua >> b[3:0]);
      4'd6:  begin s = sa - sb; r = 16'(ua - ub); ov = (s > 32767) || (s < -32768); end
      4'd7:  r = (sa < sb) ? 16'd1 : 16'd0;
      4'd8:  r = (ua < ub) ? 16'd1 : 16'd0;
      4'd9:  r = 16'(sa >>> b[3:0]);
      4'd10: begin r = 16'(ua * ub); lat = 17; end
`ifdef ALU_DIV_EN
      4'd12: begin r = (ub == 0) ? 16'hFFFF : 16'(ua / ub); dz = (ub == 0); lat = 17; end
      4'd13: begin r = (ub == 0) ? a : 16'(ua % ub); dz = (ub == 0); lat = 17; end
`endif
      default: r = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drive one request, wait (bounded) for out_valid; lat counts the accept edge as 1.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output bit ready_seen);
    int guard;
    ready_seen = 1'b0;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    ALU_CTRL = op; source1 = a; source2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) ready_seen = 1'b1;
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h exp=0000", result); end
    total++; if ({zero, overflow, div_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {zero, overflow, div_zero});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add_sub_cmp();
    logic [3:0]  ops[4]  = '{4'd2, 4'd6, 4'd7, 4'd8};
    logic [15:0] as[4]   = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFF};
    logic [15:0] bs[4]   = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    logic [15:0] exp_r[4] = '{16'h8000, 16'h7FFF, 16'h0001, 16'h0000};
    logic        exp_o[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat; bit rs;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, rs);
      total++; if (lat !== 1) begin bad++; $display("FAIL addsub_latency[%0d] got=%0d exp=1", i, lat); end
      total++; if (result !== exp_r[i]) begin bad++; $display("FAIL addsub_result[%0d] got=%h exp=%h", i, result, exp_r[i]); end
      total++; if (overflow !== exp_o[i]) begin bad++; $display("FAIL addsub_ovf[%0d] got=%b exp=%b", i, overflow, exp_o[i]); end
      total++; if (zero !== (exp_r[i] == 16'h0000)) begin bad++; $display("FAIL addsub_zero[%0d] got=%b", i, zero); end
      release_result();
    end
  endtask

  task automatic test_mul();
    int lat; bit rs;
    run_op(4'd10, 16'h0123, 16'h0045, lat, rs);
    total++; if (lat !== 17) begin bad++; $display("FAIL mul_latency got=%0d exp=17", lat); end
    total++; if (result !== 16'h4E6F) begin bad++; $display("FAIL mul_result got=%h exp=4e6f", result); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL mul_in_ready_busy got=%b exp=0", rs); end
    release_result();
  endtask

  task automatic test_div();
`ifdef ALU_DIV_EN
    logic [3:0]  ops[4]   = '{4'd12, 4'd13, 4'd12, 4'd13};
    logic [15:0] as[4]    = '{16'd100, 16'd100, 16'h1234, 16'h1234};
    logic [15:0] bs[4]    = '{16'd7, 16'd7, 16'h0000, 16'h0000};
    logic [15:0] exp_r[4] = '{16'd14, 16'd2, 16'hFFFF, 16'h1234};
    logic        exp_d[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          exp_l    = 17;
`else
    logic [3:0]  ops[4]   = '{4'd12, 4'd13, 4'd12, 4'd13};
    logic [15:0] as[4]    = '{16'd100, 16'd100, 16'h1234, 16'h1234};
    logic [15:0] bs[4]    = '{16'd7, 16'd7, 16'h0000, 16'h0000};
    logic [15:0] exp_r[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        exp_d[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          exp_l    = 1;
`endif
    int lat; bit rs;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, rs);
      total++; if (lat !== exp_l) begin bad++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, exp_l); end
      total++; if (result !== exp_r[i]) begin bad++; $display("FAIL div_result[%0d] got=%h exp=%h", i, result, exp_r[i]); end
      total++; if (div_zero !== exp_d[i]) begin bad++; $display("FAIL div_zero_flag[%0d] got=%b exp=%b", i, div_zero, exp_d[i]); end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit rs;
    run_op(4'd9, 16'h8000, 16'h0013, lat, rs);
    total++; if (result !== 16'hF000) begin bad++; $display("FAIL sra_result got=%h exp=f000", result); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 16'hF000}) begin
        bad++; $display("FAIL hold[%0d] got v=%b r=%b res=%h exp v=1 r=0 res=f000", i, out_valid, in_ready, result);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    total++; if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat; bit rs;
    @(negedge clk);
    ALU_CTRL = 4'd10; source1 = 16'h00FF; source2 = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2; rst = 1'b1; #1;
    total++; if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 16'h0000}) begin
      bad++; $display("FAIL midreset got v=%b r=%b res=%h exp v=0 r=1 res=0000", out_valid, in_ready, result);
    end
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_discard got=%b exp=0", out_valid); end
    run_op(4'd0, 16'h0F0F, 16'h00FF, lat, rs);
    total++; if (result !== 16'h000F || lat !== 1) begin
      bad++; $display("FAIL and_after_reset got=%h lat=%0d exp=000f lat=1", result, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, b1, a2, b2, e1, e2;
    logic o, d; int l;
    a1 = pick(); b1 = pick(); a2 = pick(); b2 = pick();
    model(4'd3, a1, b1, e1, o, d, l);
    model(4'd6, a2, b2, e2, o, d, l);
    @(negedge clk);
    out_ready = 1'b1; ALU_CTRL = 4'd3; source1 = a1; source2 = b1; in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if ({out_valid, result} !== {1'b1, e1}) begin
      bad++; $display("FAIL b2b_first got v=%b res=%h exp v=1 res=%h", out_valid, result, e1);
    end
    ALU_CTRL = 4'd6; source1 = a2; source2 = b2;
    @(posedge clk); #1;
    total++; if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL b2b_gap got ready=%b valid=%b exp 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    total++; if ({out_valid, result} !== {1'b1, e2}) begin
      bad++; $display("FAIL b2b_second got v=%b res=%h exp v=1 res=%h", out_valid, result, e2);
    end
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] op; logic [15:0] a, b, er; logic eo, ed; int el, lat; bit rs;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick(); b = pick();
      model(op, a, b, er, eo, ed, el);
      run_op(op, a, b, lat, rs);
      total++; if (result !== er) begin bad++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, result, er); end
      total++; if ({zero, overflow, div_zero} !== {er == 16'h0000, eo, ed}) begin
        bad++; $display("FAIL rand_flags op=%0d a=%h b=%h got=%b exp=%b", op, a, b,
                        {zero, overflow, div_zero}, {er == 16'h0000, eo, ed});
      end
      total++; if (lat !== el) begin bad++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", op, lat, el); end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_add_sub_cmp();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
